multiplier_timing: RTL and testbench

Multi-cycle reconstruction multiplier. It computes Product = Qin*Yin + Rin by repeated addition, performing up to three additions of Yin per clock. It is the inverse operation of the team's divider: given a quotient, divisor and remainder, it rebuilds the dividend. It uses the same Start/Done/Ack handshake, so it can sit directly behind the divider in the lab datapath as a self-check stage.

---
 rtl/multiplier_timing.sv | 103 ++++++++++
 tb/tb_multiplier_timing.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_timing.sv
// Multi-cycle reconstruction multiplier: Product = Qin*Yin + Rin.
// Adds the multiplicand into the accumulator up to three times per clock.
// Start/Done/Ack handshake matches the divider, so this block can follow it
// as a self-check stage.
//
// state   | meaning
// --------+-----------------------------------------------------------
// INITIAL | idle; operands reloaded every clock, Start launches a run
// COMPUTE | up to three additions of y per clock until count reaches 0
// DONE_S  | result held on Product, Done high, waiting for Ack

module multiplier_timing (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic [3:0] Qin,
   input  logic [3:0] Yin,
   input  logic [3:0] Rin,
   input  logic       Start,
   input  logic       Ack,
   output logic       Done,
   output logic [7:0] Product
);

   localparam logic [2:0] INITIAL = 3'b001;
   localparam logic [2:0] COMPUTE = 3'b010;
   localparam logic [2:0] DONE_S  = 3'b100;

   logic [2:0] state;
   logic [2:0] state_nxt;

   logic [7:0] acc;
   logic [3:0] count;
   logic [3:0] y;

   logic [7:0] acc_step;
   logic [3:0] count_step;

   // State register; reset aborts any run in progress.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= INITIAL;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; COMPUTE exit looks at the registered count.
   always_comb begin
      state_nxt = state;
      case (state)
         INITIAL: if (Start)          state_nxt = COMPUTE;
         COMPUTE: if (count == 4'd0)  state_nxt = DONE_S;
         DONE_S:  if (Ack)            state_nxt = INITIAL;
         default:                     state_nxt = INITIAL;
      endcase
   end

   // Outputs decoded straight from state and the accumulator.
   always_comb begin
      Done    = (state == DONE_S);
      Product = acc;
   end

   // Three chained add stages; each one is skipped once the count runs out.
   always_comb begin
      acc_step   = acc;
      count_step = count;
      for (int i = 0; i < 3; i++) begin
         if (count_step != 4'd0) begin
            acc_step   = acc_step + {4'b0, y};
            count_step = count_step - 4'd1;
         end
      end
   end

   // Datapath registers: continuous operand load while idle, accumulate in
   // COMPUTE, hold in DONE_S. Max result 240 fits in 8 bits.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         acc   <= 8'd0;
         count <= 4'd0;
         y     <= 4'd0;
      end else begin
         case (state)
            INITIAL: begin
               acc   <= {4'b0, Rin};
               count <= Qin;
               y     <= Yin;
            end
            COMPUTE: begin
               acc   <= acc_step;
               count <= count_step;
            end
            default: begin
               acc   <= acc;
               count <= count;
               y     <= y;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multiplier_timing.sv
// Directed bench for multiplier_timing: reset, latency, handshake and a full
// operand sweep against Q*Y+R and ceil(Q/3)+1.

module tb_multiplier_timing;

   logic       Clk;
   logic       Reset_n;
   logic [3:0] Qin;
   logic [3:0] Yin;
   logic [3:0] Rin;
   logic       Start;
   logic       Ack;
   logic       Done;
   logic [7:0] Product;

   int n_checks;
   int n_fail;

   multiplier_timing dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .Qin     (Qin),
      .Yin     (Yin),
      .Rin     (Rin),
      .Start   (Start),
      .Ack     (Ack),
      .Done    (Done),
      .Product (Product)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // One full operation: launch, wait for Done, check latency and result,
   // optionally check hold without Ack, then acknowledge.
   task automatic run_op(input logic [3:0] q, input logic [3:0] yv,
                         input logic [3:0] r, input logic [7:0] exp_p,
                         input int exp_lat, input int hold_cycles,
                         input string tag);
      int edges;
      Qin = q; Yin = yv; Rin = r; Start = 1'b1; Ack = 1'b0;
      @(posedge Clk); #1;
      Start = 1'b0;
      edges = 0;
      while (!Done && edges < 20) begin
         @(posedge Clk); #1;
         edges++;
      end
      n_checks++;
      if (edges !== exp_lat) begin
         n_fail++;
         $display("FAIL %s latency: got %0d edges, expected %0d (q=%0d y=%0d r=%0d)",
                  tag, edges, exp_lat, q, yv, r);
      end
      n_checks++;
      if (Product !== exp_p) begin
         n_fail++;
         $display("FAIL %s product: got %0d, expected %0d (q=%0d y=%0d r=%0d)",
                  tag, Product, exp_p, q, yv, r);
      end
      for (int i = 0; i < hold_cycles; i++) begin
         Qin = 4'($urandom); Rin = 4'($urandom); Start = 1'b1;
         @(posedge Clk); #1;
         n_checks++;
         if (Done !== 1'b1 || Product !== exp_p) begin
            n_fail++;
            $display("FAIL %s hold: Done=%b Product=%0d, expected Done=1 Product=%0d",
                     tag, Done, Product, exp_p);
         end
      end
      Start = 1'b0;
      Ack = 1'b1;
      @(posedge Clk); #1;
      Ack = 1'b0;
      n_checks++;
      if (Done !== 1'b0) begin
         n_fail++;
         $display("FAIL %s ack: Done=%b, expected 0 one edge after Ack", tag, Done);
      end
   endtask

   task automatic test_reset();
      Reset_n = 1'b0; Start = 1'b0; Ack = 1'b0;
      Qin = 4'd7; Yin = 4'd7; Rin = 4'd9;
      #2;
      n_checks++;
      if (Done !== 1'b0 || Product !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_state: Done=%b Product=%0d, expected 0/0", Done, Product);
      end
      repeat (2) @(posedge Clk);
      #3 Reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge Clk); #1;
         n_checks++;
         if (Done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_start: Done=%b, expected 0", Done);
         end
      end
   endtask

   task automatic test_basic();
      run_op(4'd7, 4'd3, 4'd2, 8'd23, 4, 3, "basic_7x3+2");
   endtask

   task automatic test_boundaries();
      run_op(4'd0,  4'd9,  4'd5,  8'd5,   1, 0, "q_zero");
      run_op(4'd15, 4'd15, 4'd15, 8'd240, 6, 0, "max");
      run_op(4'd10, 4'd0,  4'd6,  8'd6,   5, 0, "y_zero");
      run_op(4'd3,  4'd1,  4'd0,  8'd3,   2, 0, "q_three");
   endtask

   task automatic test_toggle_during_compute();
      int edges;
      Qin = 4'd9; Yin = 4'd4; Rin = 4'd3; Start = 1'b1; Ack = 1'b0;
      @(posedge Clk); #1;
      edges = 0;
      while (!Done && edges < 20) begin
         Start = ~Start;
         Qin = 4'($urandom); Yin = 4'($urandom); Rin = 4'($urandom);
         @(posedge Clk); #1;
         edges++;
      end
      n_checks++;
      if (edges !== 4) begin
         n_fail++;
         $display("FAIL toggle latency: got %0d edges, expected 4", edges);
      end
      n_checks++;
      if (Product !== 8'd39) begin
         n_fail++;
         $display("FAIL toggle product: got %0d, expected 39", Product);
      end
      Start = 1'b0; Ack = 1'b1;
      @(posedge Clk); #1;
      Ack = 1'b0;
   endtask

   task automatic test_reset_mid_compute();
      Qin = 4'd9; Yin = 4'd4; Rin = 4'd3; Start = 1'b1; Ack = 1'b0;
      @(posedge Clk); #1;
      Start = 1'b0;
      repeat (2) begin
         @(posedge Clk); #1;
      end
      // acc is 27 here, mid-run
      #1 Reset_n = 1'b0;
      #1;
      n_checks++;
      if (Done !== 1'b0 || Product !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_mid: Done=%b Product=%0d, expected 0/0", Done, Product);
      end
      Rin = 4'd3; Qin = 4'd5; Yin = 4'd2;
      #1 Reset_n = 1'b1;
      @(posedge Clk); #1;
      n_checks++;
      if (Done !== 1'b0 || Product !== 8'd3) begin
         n_fail++;
         $display("FAIL reset_reload: Done=%b Product=%0d, expected 0/3", Done, Product);
      end
      for (int i = 0; i < 4; i++) begin
         @(posedge Clk); #1;
         n_checks++;
         if (Done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: Done=%b, expected 0", Done);
         end
      end
   endtask

   task automatic test_ack_held();
      int done_cycles;
      Ack = 1'b1;
      Qin = 4'd2; Yin = 4'd5; Rin = 4'd1; Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      done_cycles = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge Clk); #1;
         if (Done) begin
            done_cycles++;
            n_checks++;
            if (Product !== 8'd11) begin
               n_fail++;
               $display("FAIL ack_held product: got %0d, expected 11", Product);
            end
         end
      end
      n_checks++;
      if (done_cycles !== 1) begin
         n_fail++;
         $display("FAIL ack_held cycles: got %0d Done cycles, expected 1", done_cycles);
      end
      Ack = 1'b0;
   endtask

   task automatic test_back_to_back();
      int done_count;
      int last_done;
      Qin = 4'd3; Yin = 4'd2; Rin = 4'd1; Start = 1'b1; Ack = 1'b1;
      @(posedge Clk); #1;
      done_count = 0;
      last_done = 0;
      for (int i = 1; i <= 16; i++) begin
         @(posedge Clk); #1;
         if (Done) begin
            n_checks++;
            if (Product !== 8'd7) begin
               n_fail++;
               $display("FAIL b2b product: got %0d, expected 7", Product);
            end
            n_checks++;
            if ((done_count == 0 && i != 2) || (done_count != 0 && i - last_done != 4)) begin
               n_fail++;
               $display("FAIL b2b spacing: Done at edge %0d, previous %0d, expected first at 2 then every 4",
                        i, last_done);
            end
            done_count++;
            last_done = i;
         end
      end
      n_checks++;
      if (done_count !== 4) begin
         n_fail++;
         $display("FAIL b2b count: got %0d results, expected 4", done_count);
      end
      Start = 1'b0;
      repeat (8) @(posedge Clk);
      #1 Ack = 1'b0;
   endtask

   task automatic test_sweep();
      logic [7:0] exp_p;
      int         lat;
      for (int q = 0; q < 16; q++) begin
         for (int yv = 0; yv < 16; yv++) begin
            for (int r = 0; r < 16; r++) begin
               exp_p = 8'(q * yv + r);
               lat = (q + 2) / 3 + 1;
               run_op(4'(q), 4'(yv), 4'(r), exp_p, lat, 0, "sweep");
            end
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      test_reset();
      test_basic();
      test_boundaries();
      test_toggle_during_compute();
      test_reset_mid_compute();
      test_ack_held();
      test_back_to_back();
      test_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
